// File: rtl/connect4_turn_arbiter.sv
// Turn-order arbiter: accepts a column request only from the player on turn,
// runs one engine op/result exchange, returns the result, and keeps score.
module connect4_turn_arbiter #(
   parameter int TURN_TIMEOUT = 1000,
   parameter int WIN_W        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             p0_req_valid,
   output logic             p0_req_ready,
   input  logic [2:0]       p0_req_col,
   input  logic             p1_req_valid,
   output logic             p1_req_ready,
   input  logic [2:0]       p1_req_col,
   output logic             p0_rsp_valid,
   input  logic             p0_rsp_ready,
   output logic             p1_rsp_valid,
   input  logic             p1_rsp_ready,
   output logic             rsp_err,
   output logic             rsp_finished,
   output logic             rsp_winner,
   output logic             rsp_tie,
   output logic             eng_op_valid,
   input  logic             eng_op_ready,
   output logic             eng_op_player_id,
   output logic [2:0]       eng_op_col_id,
   output logic             eng_re_ready,
   input  logic             eng_re_valid,
   input  logic             eng_re_err,
   input  logic             eng_re_is_finished,
   input  logic             eng_re_winner,
   input  logic             eng_re_tie,
   output logic             turn,
   output logic [5:0]       move_cnt,
   output logic [WIN_W-1:0] wins0,
   output logic [WIN_W-1:0] wins1,
   output logic             timeout_pulse
);

   localparam int CNT_W = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'((TURN_TIMEOUT > 0) ? TURN_TIMEOUT - 1 : 0);
   localparam logic TO_EN = (TURN_TIMEOUT > 0);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RE, S_RSP} state_t;

   state_t           r_state, w_state_next;
   logic             r_armed;
   logic             r_turn;
   logic             r_player;
   logic [2:0]       r_col;
   logic [5:0]       r_move_cnt;
   logic [CNT_W-1:0] r_idle_cnt;
   logic             r_timeout_pulse;
   logic             r_rsp_err, r_rsp_finished, r_rsp_winner, r_rsp_tie;

   logic             w_idle;
   logic             w_req_fire;
   logic             w_re_fire;
   logic             w_rsp_fire;
   logic             w_timeout;
   logic             w_game_over;
   logic [1:0]       w_win_inc;

   // r_armed keeps both req_ready low while reset is held and for the first cycle after
   assign w_idle      = (r_state == S_IDLE);
   assign w_req_fire  = w_idle & r_armed & (r_turn ? p1_req_valid : p0_req_valid);
   assign w_re_fire   = (r_state == S_WAIT_RE) & eng_re_valid;
   assign w_rsp_fire  = (r_state == S_RSP) & (r_player ? p1_rsp_ready : p0_rsp_ready);
   assign w_timeout   = TO_EN & w_idle & ~w_req_fire & (r_idle_cnt == IDLE_LAST);
   assign w_game_over = w_rsp_fire & ~r_rsp_err & r_rsp_finished;
   assign w_win_inc   = {w_game_over & ~r_rsp_tie & r_rsp_winner,
                         w_game_over & ~r_rsp_tie & ~r_rsp_winner};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      p0_req_ready = 1'b0;
      p1_req_ready = 1'b0;
      eng_op_valid = 1'b0;
      eng_re_ready = 1'b0;
      p0_rsp_valid = 1'b0;
      p1_rsp_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            p0_req_ready = r_armed & ~r_turn;
            p1_req_ready = r_armed & r_turn;
            if (w_req_fire) w_state_next = S_ISSUE;
         end
         S_ISSUE: begin
            eng_op_valid = 1'b1;
            if (eng_op_ready) w_state_next = S_WAIT_RE;
         end
         S_WAIT_RE: begin
            eng_re_ready = 1'b1;
            if (eng_re_valid) w_state_next = S_RSP;
         end
         S_RSP: begin
            p0_rsp_valid = ~r_player;
            p1_rsp_valid = r_player;
            if (w_rsp_fire) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_armed         <= 1'b0;
         r_turn          <= 1'b0;
         r_player        <= 1'b0;
         r_col           <= 3'd0;
         r_move_cnt      <= 6'd0;
         r_idle_cnt      <= '0;
         r_timeout_pulse <= 1'b0;
         r_rsp_err       <= 1'b0;
         r_rsp_finished  <= 1'b0;
         r_rsp_winner    <= 1'b0;
         r_rsp_tie       <= 1'b0;
      end else begin
         r_armed         <= 1'b1;
         r_timeout_pulse <= w_timeout;
         if (w_req_fire) begin
            r_player <= r_turn;
            r_col    <= r_turn ? p1_req_col : p0_req_col;
         end
         if (w_re_fire) begin
            r_rsp_err      <= eng_re_err;
            r_rsp_finished <= eng_re_is_finished;
            r_rsp_winner   <= eng_re_winner;
            r_rsp_tie      <= eng_re_tie;
         end
         if (!w_idle || w_req_fire || w_timeout || !TO_EN) r_idle_cnt <= '0;
         else                                             r_idle_cnt <= r_idle_cnt + 1'b1;
         if (w_timeout) r_turn <= ~r_turn;
         // An engine error leaves turn and move count alone so the same player retries
         if (w_rsp_fire && !r_rsp_err) begin
            if (r_rsp_finished) begin
               r_turn     <= 1'b0;
               r_move_cnt <= 6'd0;
            end else begin
               r_turn     <= ~r_turn;
               r_move_cnt <= r_move_cnt + 6'd1;
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_win
         logic [WIN_W-1:0] r_wins;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)                               r_wins <= '0;
            else if (w_win_inc[gi] && r_wins != '1) r_wins <= r_wins + 1'b1;
         end
      end
   endgenerate

   assign wins0            = g_win[0].r_wins;
   assign wins1            = g_win[1].r_wins;
   assign turn             = r_turn;
   assign move_cnt         = r_move_cnt;
   assign timeout_pulse    = r_timeout_pulse;
   assign eng_op_player_id = r_player;
   assign eng_op_col_id    = r_col;
   assign rsp_err          = r_rsp_err;
   assign rsp_finished     = r_rsp_finished;
   assign rsp_winner       = r_rsp_winner;
   assign rsp_tie          = r_rsp_tie;

endmodule

// File: tb/tb_connect4_turn_arbiter.sv
// Directed bench: table of full move transactions with hand-computed results,
// plus sequences for wrong-player requests, turn timeout and mid-transaction reset.
module tb_connect4_turn_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // main instance: 2-bit win counters (to reach saturation), timeout disabled
   logic rst;
   logic p0_req_valid, p0_req_ready, p1_req_valid, p1_req_ready;
   logic [2:0] p0_req_col, p1_req_col;
   logic p0_rsp_valid, p0_rsp_ready, p1_rsp_valid, p1_rsp_ready;
   logic rsp_err, rsp_finished, rsp_winner, rsp_tie;
   logic eng_op_valid, eng_op_ready, eng_op_player_id;
   logic [2:0] eng_op_col_id;
   logic eng_re_ready, eng_re_valid, eng_re_err, eng_re_is_finished, eng_re_winner, eng_re_tie;
   logic turn, timeout_pulse;
   logic [5:0] move_cnt;
   logic [1:0] wins0, wins1;

   connect4_turn_arbiter #(.TURN_TIMEOUT(0), .WIN_W(2)) u_dut (
      .clk(clk), .rst(rst),
      .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_col(p0_req_col),
      .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_col(p1_req_col),
      .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready),
      .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
      .rsp_err(rsp_err), .rsp_finished(rsp_finished), .rsp_winner(rsp_winner), .rsp_tie(rsp_tie),
      .eng_op_valid(eng_op_valid), .eng_op_ready(eng_op_ready),
      .eng_op_player_id(eng_op_player_id), .eng_op_col_id(eng_op_col_id),
      .eng_re_ready(eng_re_ready), .eng_re_valid(eng_re_valid), .eng_re_err(eng_re_err),
      .eng_re_is_finished(eng_re_is_finished), .eng_re_winner(eng_re_winner), .eng_re_tie(eng_re_tie),
      .turn(turn), .move_cnt(move_cnt), .wins0(wins0), .wins1(wins1), .timeout_pulse(timeout_pulse)
   );

   // timeout instance: engine and players always ready, engine always reports ok
   logic t_rst;
   logic t_p0_req_ready, t_p1_req_valid, t_p1_req_ready;
   logic t_p0_rsp_valid, t_p1_rsp_valid;
   logic t_rsp_err, t_rsp_finished, t_rsp_winner, t_rsp_tie;
   logic t_eng_op_valid, t_eng_op_player_id, t_eng_re_ready;
   logic [2:0] t_eng_op_col_id;
   logic t_turn, t_timeout_pulse;
   logic [5:0] t_move_cnt;
   logic [7:0] t_wins0, t_wins1;

   connect4_turn_arbiter #(.TURN_TIMEOUT(4), .WIN_W(8)) u_dut_to (
      .clk(clk), .rst(t_rst),
      .p0_req_valid(1'b0), .p0_req_ready(t_p0_req_ready), .p0_req_col(3'd0),
      .p1_req_valid(t_p1_req_valid), .p1_req_ready(t_p1_req_ready), .p1_req_col(3'd2),
      .p0_rsp_valid(t_p0_rsp_valid), .p0_rsp_ready(1'b1),
      .p1_rsp_valid(t_p1_rsp_valid), .p1_rsp_ready(1'b1),
      .rsp_err(t_rsp_err), .rsp_finished(t_rsp_finished), .rsp_winner(t_rsp_winner), .rsp_tie(t_rsp_tie),
      .eng_op_valid(t_eng_op_valid), .eng_op_ready(1'b1),
      .eng_op_player_id(t_eng_op_player_id), .eng_op_col_id(t_eng_op_col_id),
      .eng_re_ready(t_eng_re_ready), .eng_re_valid(1'b1), .eng_re_err(1'b0),
      .eng_re_is_finished(1'b0), .eng_re_winner(1'b0), .eng_re_tie(1'b0),
      .turn(t_turn), .move_cnt(t_move_cnt), .wins0(t_wins0), .wins1(t_wins1),
      .timeout_pulse(t_timeout_pulse)
   );

   typedef struct {
      logic       pl;
      logic [2:0] col;
      logic       err, fin, win, tie;
      logic       exp_turn;
      logic [5:0] exp_mc;
      logic [1:0] exp_w0, exp_w1;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int n;
      string s;
      s = $sformatf("v%0d", idx);
      if (v.pl) begin p1_req_valid = 1'b1; p1_req_col = v.col; end
      else      begin p0_req_valid = 1'b1; p0_req_col = v.col; end
      n = 0;
      while (!(v.pl ? p1_req_ready : p0_req_ready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({s, " req_ready_wait"}, (n < 20), 1);
      chk({s, " other_req_ready"}, v.pl ? p0_req_ready : p1_req_ready, 0);
      @(posedge clk);
      #1;
      p0_req_valid = 1'b0; p1_req_valid = 1'b0;
      p0_req_col = ~v.col; p1_req_col = ~v.col;
      @(negedge clk);
      chk({s, " eng_op_valid"}, eng_op_valid, 1);
      chk({s, " eng_op_player"}, eng_op_player_id, v.pl);
      chk({s, " eng_op_col"}, eng_op_col_id, v.col);
      @(negedge clk);
      chk({s, " eng_op_valid_hold"}, eng_op_valid, 1);
      chk({s, " eng_op_col_hold"}, eng_op_col_id, v.col);
      eng_op_ready = 1'b1;
      @(posedge clk);
      #1 eng_op_ready = 1'b0;
      @(negedge clk);
      chk({s, " eng_op_valid_drop"}, eng_op_valid, 0);
      chk({s, " eng_re_ready"}, eng_re_ready, 1);
      eng_re_valid = 1'b1; eng_re_err = v.err; eng_re_is_finished = v.fin;
      eng_re_winner = v.win; eng_re_tie = v.tie;
      @(posedge clk);
      #1;
      eng_re_valid = 1'b0; eng_re_err = ~v.err; eng_re_is_finished = ~v.fin;
      eng_re_winner = ~v.win; eng_re_tie = ~v.tie;
      @(negedge clk);
      chk({s, " eng_re_ready_drop"}, eng_re_ready, 0);
      chk({s, " rsp_valid_req"}, v.pl ? p1_rsp_valid : p0_rsp_valid, 1);
      chk({s, " rsp_valid_other"}, v.pl ? p0_rsp_valid : p1_rsp_valid, 0);
      chk({s, " rsp_fields"}, {rsp_err, rsp_finished, rsp_winner, rsp_tie}, {v.err, v.fin, v.win, v.tie});
      @(negedge clk);
      chk({s, " rsp_valid_hold"}, v.pl ? p1_rsp_valid : p0_rsp_valid, 1);
      chk({s, " rsp_fields_hold"}, {rsp_err, rsp_finished, rsp_winner, rsp_tie}, {v.err, v.fin, v.win, v.tie});
      if (v.pl) p1_rsp_ready = 1'b1; else p0_rsp_ready = 1'b1;
      @(posedge clk);
      #1 begin p0_rsp_ready = 1'b0; p1_rsp_ready = 1'b0; end
      @(negedge clk);
      chk({s, " rsp_valid_drop"}, p0_rsp_valid | p1_rsp_valid, 0);
      chk({s, " turn"}, turn, v.exp_turn);
      chk({s, " move_cnt"}, move_cnt, v.exp_mc);
      chk({s, " wins0"}, wins0, v.exp_w0);
      chk({s, " wins1"}, wins1, v.exp_w1);
      $display("vec %0d p%0d col=%0d err=%0d fin=%0d -> turn=%0d move_cnt=%0d wins=%0d/%0d",
               idx, v.pl, v.col, v.err, v.fin, turn, move_cnt, wins0, wins1);
   endtask

   task automatic chk_all_zero(input string s);
      chk({s, " req_ready"}, {p0_req_ready, p1_req_ready}, 0);
      chk({s, " rsp_valid"}, {p0_rsp_valid, p1_rsp_valid}, 0);
      chk({s, " rsp_fields"}, {rsp_err, rsp_finished, rsp_winner, rsp_tie}, 0);
      chk({s, " eng_op"}, {eng_op_valid, eng_op_player_id, eng_op_col_id}, 0);
      chk({s, " eng_re_ready"}, eng_re_ready, 0);
      chk({s, " turn"}, turn, 0);
      chk({s, " move_cnt"}, move_cnt, 0);
      chk({s, " wins"}, {wins0, wins1}, 0);
      chk({s, " timeout_pulse"}, timeout_pulse, 0);
   endtask

   initial begin
      //          pl    col  err fin win tie turn mc     w0    w1
      vecs[0]  = '{1'b0, 3'd3, 0, 0, 0, 0, 1'b1, 6'd1, 2'd0, 2'd0};
      vecs[1]  = '{1'b1, 3'd3, 1, 0, 0, 0, 1'b1, 6'd1, 2'd0, 2'd0};
      vecs[2]  = '{1'b1, 3'd2, 0, 0, 0, 0, 1'b0, 6'd2, 2'd0, 2'd0};
      vecs[3]  = '{1'b0, 3'd0, 0, 0, 0, 0, 1'b1, 6'd3, 2'd0, 2'd0};
      vecs[4]  = '{1'b1, 3'd1, 0, 0, 0, 0, 1'b0, 6'd4, 2'd0, 2'd0};
      vecs[5]  = '{1'b0, 3'd0, 0, 0, 0, 0, 1'b1, 6'd5, 2'd0, 2'd0};
      vecs[6]  = '{1'b1, 3'd1, 0, 0, 0, 0, 1'b0, 6'd6, 2'd0, 2'd0};
      vecs[7]  = '{1'b0, 3'd0, 0, 0, 0, 0, 1'b1, 6'd7, 2'd0, 2'd0};
      vecs[8]  = '{1'b1, 3'd1, 0, 0, 0, 0, 1'b0, 6'd8, 2'd0, 2'd0};
      vecs[9]  = '{1'b0, 3'd0, 0, 1, 0, 0, 1'b0, 6'd0, 2'd1, 2'd0};
      vecs[10] = '{1'b0, 3'd6, 0, 1, 1, 1, 1'b0, 6'd0, 2'd1, 2'd0};
      vecs[11] = '{1'b0, 3'd5, 1, 0, 0, 0, 1'b0, 6'd0, 2'd1, 2'd0};
      vecs[12] = '{1'b0, 3'd7, 0, 0, 0, 0, 1'b1, 6'd1, 2'd1, 2'd0};
      vecs[13] = '{1'b1, 3'd4, 0, 1, 1, 0, 1'b0, 6'd0, 2'd1, 2'd1};
      vecs[14] = '{1'b0, 3'd0, 0, 1, 0, 0, 1'b0, 6'd0, 2'd2, 2'd1};
      vecs[15] = '{1'b0, 3'd0, 0, 1, 0, 0, 1'b0, 6'd0, 2'd3, 2'd1};
      vecs[16] = '{1'b0, 3'd0, 0, 1, 0, 0, 1'b0, 6'd0, 2'd3, 2'd1};

      rst = 1'b1; t_rst = 1'b1; t_p1_req_valid = 1'b0;
      p0_req_valid = 1'b0; p1_req_valid = 1'b0; p0_req_col = 3'd0; p1_req_col = 3'd0;
      p0_rsp_ready = 1'b0; p1_rsp_ready = 1'b0;
      eng_op_ready = 1'b0; eng_re_valid = 1'b0; eng_re_err = 1'b0;
      eng_re_is_finished = 1'b0; eng_re_winner = 1'b0; eng_re_tie = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      // player 1 out of turn: must never be accepted or forwarded
      p1_req_valid = 1'b1; p1_req_col = 3'd2;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("wrong_player c%0d p1_req_ready", i), p1_req_ready, 0);
         chk($sformatf("wrong_player c%0d eng_op_valid", i), eng_op_valid, 0);
         chk($sformatf("wrong_player c%0d turn", i), turn, 0);
      end
      chk("wrong_player p0_req_ready", p0_req_ready, 1);
      p1_req_valid = 1'b0;
      $display("seq wrong_player: p1 held off, turn=%0d", turn);

      for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

      // reset landing while waiting on the engine result
      p0_req_valid = 1'b1; p0_req_col = 3'd1;
      @(posedge clk);
      #1 p0_req_valid = 1'b0;
      eng_op_ready = 1'b1;
      @(posedge clk);
      #1 eng_op_ready = 1'b0;
      @(negedge clk);
      chk("rst_mid eng_re_ready_before", eng_re_ready, 1);
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("rst_mid");
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid p0_req_ready_after", p0_req_ready, 1);
      chk("rst_mid eng_re_ready_after", eng_re_ready, 0);
      chk("rst_mid eng_op_valid_after", eng_op_valid, 0);
      $display("seq reset_mid_wait: turn=%0d move_cnt=%0d wins=%0d/%0d", turn, move_cnt, wins0, wins1);

      // timeout instance: forfeit on 4th idle cycle, then a fire on the 4th idle cycle wins
      t_rst = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         chk($sformatf("timeout idle%0d pulse", i), t_timeout_pulse, 0);
         chk($sformatf("timeout idle%0d turn", i), t_turn, 0);
      end
      @(negedge clk);
      chk("timeout idle4 pulse", t_timeout_pulse, 1);
      chk("timeout idle4 turn", t_turn, 1);
      chk("timeout idle4 move_cnt", t_move_cnt, 0);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         chk($sformatf("timeout re_idle%0d pulse", i), t_timeout_pulse, 0);
      end
      t_p1_req_valid = 1'b1;
      @(negedge clk);
      t_p1_req_valid = 1'b0;
      chk("timeout fire pulse", t_timeout_pulse, 0);
      chk("timeout fire turn", t_turn, 1);
      chk("timeout fire eng_op_valid", t_eng_op_valid, 1);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         chk($sformatf("timeout txn%0d pulse", i), t_timeout_pulse, 0);
      end
      chk("timeout txn turn", t_turn, 0);
      chk("timeout txn move_cnt", t_move_cnt, 1);
      $display("seq timeout: turn=%0d move_cnt=%0d", t_turn, t_move_cnt);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
